led_blink_sender: RTL

//  - Output-side counterpart to the button input path: takes a 4-bit value and sends it to the user
//    as N visible LED blinks, followed by a blank gap.
//  - Human-timed (hundreds of ms at 12 MHz); start/busy/done handshake toward the controlling logic.
//  - Sits between a counter/status register and one board LED (icestick).

---
 rtl/led_blink_sender_pkg.sv | 28 ++
 rtl/led_blink_sender_cycle_timer.sv | 29 ++
 rtl/led_blink_sender.sv | 108 ++++++++++
 3 files changed

// File: rtl/led_blink_sender_pkg.sv
// Shared icestick UI constants: clock rate, ms-to-cycles helper and the 3-bit
// state encodings used by the LED sender and its sibling UI blocks.
package led_blink_sender_pkg;

    localparam int CLK_HZ = 12_000_000;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ON   = 3'd1;
    localparam logic [2:0] ST_OFF  = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A timer that counts 0..max-1 needs at least one bit even when max is 1.
    function automatic int timer_width(input int max_cycles);
        return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/led_blink_sender_cycle_timer.sv
// Free-running cycle counter with synchronous clear, count enable and a
// terminal-count flag raised when the count equals the supplied last value.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // The owner clears on terminal count, so the counter never runs past last.
    assign tc = (count == last);

endmodule

// File: rtl/led_blink_sender.sv
// Sends a 4-bit value to the user as that many LED blinks followed by a dark
// gap, with a start/busy/done handshake toward the controlling logic.
module led_blink_sender
    import led_blink_sender_pkg::*;
#(
    parameter int COUNT_W    = 4,
    parameter int ON_CYCLES  = ms_to_cycles(200),
    parameter int OFF_CYCLES = ms_to_cycles(200),
    parameter int GAP_CYCLES = ms_to_cycles(1000)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] value,
    output logic               busy,
    output logic               done,
    output logic               led
);

    // Handshake: start is honoured only while busy is low; busy rises the next
    // cycle and stays high through the single-cycle done pulse.
    localparam int TW = timer_width(max3(ON_CYCLES, OFF_CYCLES, GAP_CYCLES));
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [COUNT_W-1:0] remaining;
    logic [COUNT_W-1:0] remaining_nxt;
    logic [TW-1:0]      timer_last;
    logic               timer_clear;
    logic               timer_en;
    logic               timer_tc;

    cycle_timer #(
        .W(TW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear),
        .en   (timer_en),
        .last (timer_last),
        .tc   (timer_tc)
    );

    always_comb begin
        timer_last = ON_LAST;
        case (state)
            ST_OFF:  timer_last = OFF_LAST;
            ST_GAP:  timer_last = GAP_LAST;
            default: timer_last = ON_LAST;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    remaining_nxt = value;
                    state_nxt     = (value != '0) ? ST_ON : ST_GAP;
                end
            end
            ST_ON: begin
                if (timer_tc) begin
                    state_nxt = ST_OFF;
                    if (remaining != '0) begin
                        remaining_nxt = remaining - 1'b1;
                    end
                end
            end
            ST_OFF: begin
                if (timer_tc) begin
                    state_nxt = (remaining != '0) ? ST_ON : ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer_tc) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Every state change restarts the timer from zero.
    assign timer_clear = (state_nxt != state);
    assign timer_en    = (state == ST_ON) || (state == ST_OFF) || (state == ST_GAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            led       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            led       <= (state_nxt == ST_ON);
            busy      <= (state_nxt != ST_IDLE);
            done      <= (state_nxt == ST_DONE);
        end
    end

endmodule
